// File: rtl/e_mdu_ctrl_pkg.sv
// mdu_defs: MDU opcode encodings, default busy-window lengths and state codes
package mdu_defs;
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_t;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
endpackage

// File: rtl/e_mdu_ctrl_if.sv
// e_mdu_ctrl_if: E-stage MDU request/response bundle between pipeline and MDU
interface e_mdu_ctrl_if;
  import mdu_defs::*;
  mdu_op_t     E_MDUOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_IsMDU;
  logic        E_Start;
  logic        E_Busy;
  logic [31:0] E_MDUOut;
  logic        D_MDUStall;
  modport master (output E_MDUOp, E_A, E_B, D_IsMDU, input E_Start, E_Busy, E_MDUOut, D_MDUStall);
  modport slave (input E_MDUOp, E_A, E_B, D_IsMDU, output E_Start, E_Busy, E_MDUOut, D_MDUStall);
endinterface

// File: rtl/e_mdu_ctrl_arith.sv
// e_mdu_arith: combinational multiply/divide datapath producing HI/LO results
module e_mdu_arith
  import mdu_defs::*;
(
  input  mdu_op_t     op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] resHI,
  output logic [31:0] resLO,
  output logic        divZero
);
  logic        is_mul, sgn, a_neg, b_neg;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, b_safe, q, r;
  assign is_mul  = op == MDU_MULT || op == MDU_MULTU;
  assign sgn     = op == MDU_MULT || op == MDU_DIV;
  assign prod    = {{32{sgn & A[31]}}, A} * {{32{sgn & B[31]}}, B};
  // Divide on magnitudes so the most-negative dividend and a zero divisor never trap
  assign a_neg   = sgn & A[31];
  assign b_neg   = sgn & B[31];
  assign a_mag   = a_neg ? -A : A;
  assign b_mag   = b_neg ? -B : B;
  assign divZero = (op == MDU_DIV || op == MDU_DIVU) && B == 32'd0;
  assign b_safe  = divZero ? 32'd1 : b_mag;
  assign q       = a_mag / b_safe;
  assign r       = a_mag % b_safe;
  assign resHI   = is_mul ? prod[63:32] : (a_neg ? -r : r);
  assign resLO   = is_mul ? prod[31:0] : ((a_neg ^ b_neg) ? -q : q);
endmodule

// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: E-stage MDU sequencer owning HI/LO, busy window and decode stall
module e_mdu_ctrl
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input logic clk,
  input logic reset_n,
  e_mdu_ctrl_if.slave bus
);
  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] hi, lo, p_hi, p_lo, res_hi, res_lo;
  logic        div_zero, is_mul, is_arith;
  e_mdu_arith u_arith (
    .op(bus.E_MDUOp),
    .A(bus.E_A),
    .B(bus.E_B),
    .resHI(res_hi),
    .resLO(res_lo),
    .divZero(div_zero)
  );
  assign is_mul         = bus.E_MDUOp == MDU_MULT || bus.E_MDUOp == MDU_MULTU;
  assign is_arith       = is_mul || bus.E_MDUOp == MDU_DIV || bus.E_MDUOp == MDU_DIVU;
  assign bus.E_Busy     = state == BUSY;
  assign bus.E_Start    = is_arith && state == IDLE;
  assign bus.D_MDUStall = bus.D_IsMDU && (bus.E_Start || bus.E_Busy);
  assign bus.E_MDUOut   = bus.E_MDUOp == MDU_MFHI ? hi : bus.E_MDUOp == MDU_MFLO ? lo : 32'd0;
  // Capture results into shadows on start, count the window down, commit on the last busy edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      p_hi  <= 32'd0;
      p_lo  <= 32'd0;
    end else if (state == IDLE) begin
      if (bus.E_Start) begin
        p_hi  <= div_zero ? hi : res_hi;
        p_lo  <= div_zero ? lo : res_lo;
        cnt   <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        state <= BUSY;
      end else if (bus.E_MDUOp == MDU_MTHI) begin
        hi <= bus.E_A;
      end else if (bus.E_MDUOp == MDU_MTLO) begin
        lo <= bus.E_A;
      end
    end else if (cnt == 4'd1) begin
      hi    <= p_hi;
      lo    <= p_lo;
      cnt   <= 4'd0;
      state <= IDLE;
    end else begin
      cnt <= cnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_e_mdu_ctrl.sv
// tb_e_mdu_ctrl: directed self-checking bench for the E-stage MDU controller
module tb_e_mdu_ctrl;
  import mdu_defs::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int failed = 0;
  e_mdu_ctrl_if bus();
  e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;

  // Writes to HI/LO while busy must never be presented by a correct pipeline
  always @(posedge clk)
    if (reset_n && bus.E_Busy && (bus.E_MDUOp == MDU_MTHI || bus.E_MDUOp == MDU_MTLO)) begin
      tests++;
      failed++;
      $display("FAIL mt_while_busy: op=%0d issued with E_Busy=1", bus.E_MDUOp);
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.E_MDUOp = MDU_NONE;
    bus.E_A = 32'd0;
    bus.E_B = 32'd0;
    bus.D_IsMDU = 1'b0;
  endtask

  task automatic check_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.E_MDUOp = MDU_MFHI;
    #1;
    tests++;
    if (bus.E_MDUOut !== exp_hi) begin
      failed++;
      $display("FAIL %s_hi: got %h expected %h", name, bus.E_MDUOut, exp_hi);
    end
    bus.E_MDUOp = MDU_MFLO;
    #1;
    tests++;
    if (bus.E_MDUOut !== exp_lo) begin
      failed++;
      $display("FAIL %s_lo: got %h expected %h", name, bus.E_MDUOut, exp_lo);
    end
    bus.E_MDUOp = MDU_NONE;
    #1;
  endtask

  task automatic run_op(input string name, input mdu_op_t op, input logic [31:0] a, input logic [31:0] b, input int exp_n);
    int n = 0;
    bus.E_MDUOp = op;
    bus.E_A = a;
    bus.E_B = b;
    #1;
    tests++;
    if (bus.E_Start !== 1'b1) begin
      failed++;
      $display("FAIL %s_start: got %b expected 1", name, bus.E_Start);
    end
    step();
    idle_inputs();
    while (bus.E_Busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    tests++;
    if (n != exp_n) begin
      failed++;
      $display("FAIL %s_busy_cycles: got %0d expected %0d", name, n, exp_n);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    tests++;
    if (bus.E_Busy !== 1'b0 || bus.E_Start !== 1'b0 || bus.D_MDUStall !== 1'b0) begin
      failed++;
      $display("FAIL reset_ctrl: busy=%b start=%b stall=%b expected 0 0 0", bus.E_Busy, bus.E_Start, bus.D_MDUStall);
    end
    check_hilo("reset", 32'h0, 32'h0);
  endtask

  task automatic test_mult();
    run_op("mult", MDU_MULT, 32'hFFFFFFFE, 32'd3, 5);
    check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
  endtask

  task automatic test_multu();
    run_op("multu", MDU_MULTU, 32'hFFFFFFFF, 32'd2, 5);
    check_hilo("multu", 32'h00000001, 32'hFFFFFFFE);
  endtask

  task automatic test_div_stall();
    int n = 0;
    int stalls = 0;
    bus.E_MDUOp = MDU_DIV;
    bus.E_A = 32'hFFFFFFF9;
    bus.E_B = 32'd2;
    bus.D_IsMDU = 1'b1;
    #1;
    if (bus.D_MDUStall === 1'b1) stalls++;
    step();
    bus.E_MDUOp = MDU_NONE;
    while (bus.E_Busy === 1'b1 && n < 40) begin
      n++;
      if (bus.D_MDUStall === 1'b1) stalls++;
      step();
    end
    tests++;
    if (n != 10) begin
      failed++;
      $display("FAIL div_busy_cycles: got %0d expected 10", n);
    end
    tests++;
    if (stalls != 11) begin
      failed++;
      $display("FAIL div_stall_cycles: got %0d expected 11", stalls);
    end
    tests++;
    if (bus.D_MDUStall !== 1'b0) begin
      failed++;
      $display("FAIL stall_after_window: got %b expected 0", bus.D_MDUStall);
    end
    idle_inputs();
    check_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
  endtask

  task automatic test_divu_zero();
    int n = 0;
    bus.E_MDUOp = MDU_MTHI;
    bus.E_A = 32'h11;
    step();
    bus.E_MDUOp = MDU_MTLO;
    bus.E_A = 32'h22;
    step();
    idle_inputs();
    check_hilo("mt", 32'h11, 32'h22);
    bus.E_MDUOp = MDU_DIVU;
    bus.E_A = 32'd5;
    bus.E_B = 32'd0;
    step();
    bus.E_MDUOp = MDU_MULT;
    bus.D_IsMDU = 1'b0;
    #1;
    tests++;
    if (bus.E_Start !== 1'b0 || bus.D_MDUStall !== 1'b0) begin
      failed++;
      $display("FAIL start_while_busy: start=%b stall=%b expected 0 0", bus.E_Start, bus.D_MDUStall);
    end
    idle_inputs();
    while (bus.E_Busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    tests++;
    if (n != 10) begin
      failed++;
      $display("FAIL divu0_busy_cycles: got %0d expected 10", n);
    end
    check_hilo("divu0", 32'h11, 32'h22);
  endtask

  task automatic test_div_overflow();
    run_op("divovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 10);
    check_hilo("divovf", 32'h0, 32'h80000000);
  endtask

  task automatic test_reset_abort();
    bus.E_MDUOp = MDU_DIV;
    bus.E_A = 32'd100;
    bus.E_B = 32'd7;
    step();
    idle_inputs();
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    tests++;
    if (bus.E_Busy !== 1'b0) begin
      failed++;
      $display("FAIL abort_busy: got %b expected 0", bus.E_Busy);
    end
    check_hilo("abort", 32'h0, 32'h0);
    reset_n = 1'b1;
    step();
    repeat (12) step();
    check_hilo("post_abort", 32'h0, 32'h0);
    run_op("mult34", MDU_MULT, 32'd3, 32'd4, 5);
    check_hilo("mult34", 32'h0, 32'd12);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div_stall();
    test_divu_zero();
    test_div_overflow();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/e_mdu_ctrl.md
# e_mdu_ctrl

Execute-stage multiply/divide controller for the five-stage MIPS pipeline. It accepts MDU instructions from E, sequences a fixed-latency busy window, owns the HI/LO registers, and produces the MDU read-back value for the E result mux. It also raises the decode-stage stall while an MDU operation is pending. It sits beside the ALU and consumes the same forwarded operands as the ALU A/B inputs.

## Interface

Parameters:
- MULT_CYCLES, 5: busy-window length for mult/multu.
- DIV_CYCLES, 10: busy-window length for div/divu.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- E_MDUOp  in  4  E-stage MDU opcode: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- E_A  in  32  forwarded rs value.
- E_B  in  32  forwarded rt value.
- D_IsMDU  in  1  decode-stage instruction is any MDU opcode.
- E_Start  out  1  combinational; E_MDUOp is MULT/MULTU/DIV/DIVU and E_Busy=0.
- E_Busy  out  1  registered; operation in progress.
- E_MDUOut  out  32  combinational; HI when E_MDUOp=MFHI, LO when E_MDUOp=MFLO, otherwise 0.
- D_MDUStall  out  1  combinational; D_IsMDU & (E_Start | E_Busy).

## Operation

- The block has two states, IDLE and BUSY, encoded by E_Busy, plus a 4-bit down-counter cnt.
- IDLE with E_Start=1:
  - Compute the result into shadow registers pHI and pLO.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY.
- BUSY: decrement cnt each cycle.
  - On the edge where cnt==1: commit pHI→HI and pLO→LO, clear cnt, go to IDLE.
- Arithmetic:
  - MULT: {HI,LO} = signed 32×32 → 64-bit product.
  - MULTU: {HI,LO} = unsigned 32×32 → 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (E_B==0, DIV/DIVU): the full DIV_CYCLES busy window still runs; HI and LO are left unchanged at commit.
- MTHI / MTLO:
  - In IDLE: write E_A into HI/LO on the next edge.
  - While E_Busy=1: the write is ignored. The stall logic prevents this case; the bench flags it as an assertion.
- MFHI / MFLO: E_MDUOut reflects the committed HI/LO only; shadow registers are never visible.
- A start request while E_Busy=1 is ignored. D_MDUStall holds the requester in D, so this does not occur legally.
- Non-MDU instructions do not stall, even while E_Busy=1.

## Timing

- Reset (asynchronous assert, synchronous release):
  - HI=0, LO=0, pHI=0, pLO=0, cnt=0, E_Busy=0.
  - Combinational outputs then follow their inputs: E_Start=0 and D_MDUStall=0 unless driven.
- Start is accepted at the edge ending cycle t, when E_Start=1.
  - E_Busy is high in cycles t+1 … t+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO hold new values from cycle t+N+1.
- D_MDUStall is high in cycle t and in cycles t+1 … t+N whenever D_IsMDU=1. A dependent MFHI/MFLO therefore reaches E no earlier than cycle t+N+1.
- MTHI/MTLO accepted in cycle t: the new value is visible to an MFHI/MFLO in cycle t+1.
- Asserting reset_n low mid-operation aborts immediately: E_Busy=0, HI and LO are cleared, and no commit occurs.
- cnt never wraps. It is 0 in IDLE and never decrements below 1 in BUSY.

## Structure

- Shared package (mdu_defs):
  - MDUOp encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - Default cycle-count constants.
- One sub-module, e_mdu_arith: purely combinational.
  - Inputs: op, A, B.
  - Outputs: resHI, resLO, divZero.
- e_mdu_ctrl contains the state, counter, shadow/commit registers, the read mux and the stall logic.

## Test plan

- Reset, then MULT with A=0xFFFFFFFE (−2), B=3 → E_Busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles; MFLO in the following cycle returns 0xFFFFFFFE.
- DIV with A=−7, B=2 → 10 busy cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. D_IsMDU=1 during this window → D_MDUStall=1 for all 11 cycles (start cycle plus 10 busy).
- DIVU by zero with HI=0x11, LO=0x22 preloaded via MTHI/MTLO → 10 busy cycles; then HI=0x11, LO=0x22 unchanged.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV started, then reset_n pulsed low in busy cycle 4 → E_Busy=0, HI=LO=0 immediately; a new MULT of 3×4 afterwards gives LO=12, HI=0.
